// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;

  typedef logic [3:0]                   key_code_t;
  typedef logic [NUM_ROWS*NUM_COLS-1:0] key_map_t;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    EVAL
  } scan_state_t;

  // Index of the lowest set bit; 0 when the map is empty.
  function automatic key_code_t lowest_set(input key_map_t m);
    key_code_t idx;
    logic      found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_ROWS * NUM_COLS; i++) begin
      if (m[i] && !found) begin
        idx   = key_code_t'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// 4-bit two-flop synchronizer for the asynchronous column inputs.
module keypad_sync (
  input  logic       aclk,
  input  logic       reset,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  // Two back-to-back flops, both cleared by reset.
  always_ff @(posedge aclk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one row low at a time, samples the
// pulled-down columns, debounces whole-matrix snapshots and hands press
// events to the bus side through a valid/ready key register.
// Optional macro KEYPAD_RELEASE_EVENT_EN adds release events.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned DWELL_CYC      = 8,
  parameter int unsigned DEBOUNCE_SCANS = 2
) (
  input  logic       aclk,
  input  logic       reset,
  input  logic       en,
  output logic [3:0] row_n,
  input  logic [3:0] col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_release,
  input  logic       key_ready,
  output logic       ovf,
  input  logic       ovf_clr,
  output logic       irq
);

  localparam int unsigned    DW         = $clog2(DWELL_CYC);
  localparam logic [DW-1:0]  DWELL_LAST = DW'(DWELL_CYC - 1);
  localparam logic [3:0]     DB_TARGET  = 4'(DEBOUNCE_SCANS);

  scan_state_t   state, state_next;
  logic [1:0]    row_idx, row_next;
  logic [DW-1:0] dwell, dwell_next;
  logic          sample, do_eval;

  logic [3:0]    col_sync;
  key_map_t      snapshot, candidate, stable;
  logic [3:0]    db_cnt;
  key_map_t      cand_new, stable_new;
  logic [3:0]    cnt_new;

  key_map_t      pend_press, press_set, press_clr;
  logic          load, ovf_set;
  key_code_t     load_code;

`ifdef KEYPAD_RELEASE_EVENT_EN
  key_map_t      pend_rel, rel_set, rel_clr;
  logic          load_rel;
  logic          release_q;
`endif

  keypad_sync u_sync (
    .aclk  (aclk),
    .reset (reset),
    .d     (col),
    .q     (col_sync)
  );

  // FSM state, row index and dwell counter registers.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state   <= IDLE;
      row_idx <= '0;
      dwell   <= '0;
    end else begin
      state   <= state_next;
      row_idx <= row_next;
      dwell   <= dwell_next;
    end
  end

  // Next-state, row drive and sample/evaluate strobes; en=0 forces IDLE.
  always_comb begin
    state_next = state;
    row_next   = row_idx;
    dwell_next = dwell;
    sample     = 1'b0;
    do_eval    = 1'b0;
    row_n      = (state == DRIVE) ? ~(4'b0001 << row_idx) : 4'hF;
    if (!en) begin
      state_next = IDLE;
      row_next   = '0;
      dwell_next = '0;
    end else begin
      case (state)
        IDLE: begin
          state_next = DRIVE;
          row_next   = '0;
          dwell_next = '0;
        end
        DRIVE: begin
          if (dwell == DWELL_LAST) begin
            sample     = 1'b1;
            dwell_next = '0;
            row_next   = row_idx + 2'd1;
            if (row_idx == 2'd3) state_next = EVAL;
          end else begin
            dwell_next = dwell + 1'b1;
          end
        end
        EVAL: begin
          do_eval    = 1'b1;
          state_next = DRIVE;
          row_next   = '0;
          dwell_next = '0;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Debounce arithmetic for the end-of-scan evaluation.
  always_comb begin
    if (snapshot == candidate) begin
      cand_new = candidate;
      cnt_new  = (db_cnt == 4'hF) ? 4'hF : db_cnt + 4'd1;
    end else begin
      cand_new = snapshot;
      cnt_new  = 4'd1;
    end
    stable_new = (cnt_new == DB_TARGET) ? cand_new : stable;
  end

  // Snapshot capture and debounce registers; disabling clears the scan history.
  always_ff @(posedge aclk) begin
    if (reset || !en) begin
      snapshot  <= '0;
      candidate <= '0;
      stable    <= '0;
      db_cnt    <= '0;
    end else begin
      if (sample) snapshot[{row_idx, 2'b00} +: 4] <= col_sync;
      if (do_eval) begin
        candidate <= cand_new;
        db_cnt    <= cnt_new;
        stable    <= stable_new;
      end
    end
  end

  // Event selection: presses lowest index first, then releases; overflow detect.
  always_comb begin
    press_set = do_eval ? (stable_new & ~stable) : '0;
    press_clr = '0;
    load      = 1'b0;
    load_code = '0;
    ovf_set   = |(press_set & pend_press);
`ifdef KEYPAD_RELEASE_EVENT_EN
    rel_set   = do_eval ? (stable & ~stable_new) : '0;
    rel_clr   = '0;
    load_rel  = 1'b0;
    ovf_set   = ovf_set | (|(rel_set & pend_rel));
`endif
    if (!key_valid || key_ready) begin
      if (|pend_press) begin
        load      = 1'b1;
        load_code = lowest_set(pend_press);
        press_clr = key_map_t'(1) << load_code;
      end
`ifdef KEYPAD_RELEASE_EVENT_EN
      else if (|pend_rel) begin
        load      = 1'b1;
        load_rel  = 1'b1;
        load_code = lowest_set(pend_rel);
        rel_clr   = key_map_t'(1) << load_code;
      end
`endif
    end
  end

  // Pending masks, key register and sticky overflow flag.
  always_ff @(posedge aclk) begin
    if (reset) begin
      pend_press <= '0;
      key_valid  <= 1'b0;
      key_code   <= '0;
      ovf        <= 1'b0;
    end else begin
      pend_press <= (pend_press & ~press_clr) | press_set;
      if (load) begin
        key_valid <= 1'b1;
        key_code  <= load_code;
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

`ifdef KEYPAD_RELEASE_EVENT_EN
  // Release pending mask and the release flag of the key register.
  always_ff @(posedge aclk) begin
    if (reset) begin
      pend_rel  <= '0;
      release_q <= 1'b0;
    end else begin
      pend_rel <= (pend_rel & ~rel_clr) | rel_set;
      if (load) release_q <= load_rel;
    end
  end

  assign key_release = release_q;
`else
  assign key_release = 1'b0;
`endif

  assign irq = key_valid;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a behavioural keypad model.
module tb_keypad_scanner;

  logic        aclk = 1'b0;
  logic        reset, en, key_ready, ovf_clr;
  logic [3:0]  row_n, col, key_code;
  logic        key_valid, key_release, ovf, irq;
  logic [15:0] keys;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] code;
    logic       rel;
  } exp_t;

  exp_t sb[$];

  always #5 aclk = ~aclk;

  // Keypad model: a closed key pulls its column high while its row is low.
  always_comb begin
    col = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && row_n[r] === 1'b0) col[c] = 1'b1;
  end

  keypad_scanner #(
    .DWELL_CYC      (8),
    .DEBOUNCE_SCANS (2)
  ) dut (
    .aclk        (aclk),
    .reset       (reset),
    .en          (en),
    .row_n       (row_n),
    .col         (col),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_release (key_release),
    .key_ready   (key_ready),
    .ovf         (ovf),
    .ovf_clr     (ovf_clr),
    .irq         (irq)
  );

  task automatic do_reset();
    reset     = 1'b1;
    en        = 1'b0;
    key_ready = 1'b1;
    ovf_clr   = 1'b0;
    keys      = '0;
    sb.delete();
    repeat (3) @(negedge aclk);
    reset = 1'b0;
  endtask

  // Advance to the negedge inside the next EVAL cycle (row_n idle after driving).
  task automatic wait_eval();
    bit seen_drive = 0;
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge aclk);
      if (row_n !== 4'hF) seen_drive = 1;
      else if (seen_drive) done = 1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL eval_timeout: no scan end within 200 cycles");
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; key_ready = 1'b0; ovf_clr = 1'b0; keys = '0;
    repeat (2) @(negedge aclk);
    total++; if (row_n !== 4'hF)      begin bad++; $display("FAIL rst_row_n: got %h want f", row_n); end
    total++; if (key_valid !== 1'b0)  begin bad++; $display("FAIL rst_key_valid: got %b want 0", key_valid); end
    total++; if (key_code !== 4'h0)   begin bad++; $display("FAIL rst_key_code: got %h want 0", key_code); end
    total++; if (key_release !== 1'b0) begin bad++; $display("FAIL rst_key_release: got %b want 0", key_release); end
    total++; if (ovf !== 1'b0)        begin bad++; $display("FAIL rst_ovf: got %b want 0", ovf); end
    total++; if (irq !== 1'b0)        begin bad++; $display("FAIL rst_irq: got %b want 0", irq); end
    reset = 1'b0;
  endtask

  // Keys 0 and 5 held, ready high: first event 67 edges after en is sampled,
  // both events on consecutive cycles, nothing more while held.
  task automatic test_back_to_back();
    int   edge_n = -1;
    int   first = -1;
    int   last_pop = -1;
    exp_t e;
    do_reset();
    keys = 16'h0021;
    sb.push_back('{code: 4'd0, rel: 1'b0});
    sb.push_back('{code: 4'd5, rel: 1'b0});
    en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge aclk); edge_n++;
      @(negedge aclk);
      if (key_valid && first < 0) first = edge_n;
      if (key_valid && key_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL b2b_extra: unexpected code %h", key_code);
        end else begin
          e = sb.pop_front();
          if (key_code !== e.code || key_release !== e.rel) begin
            bad++; $display("FAIL b2b_event: got %h/%b want %h/%b", key_code, key_release, e.code, e.rel);
          end
          if (last_pop >= 0) begin
            total++;
            if (edge_n != last_pop + 1) begin
              bad++; $display("FAIL b2b_spacing: got edge %0d want %0d", edge_n, last_pop + 1);
            end
          end
          last_pop = edge_n;
        end
      end
    end
    total++; if (first != 67) begin bad++; $display("FAIL b2b_latency: got %0d want 67", first); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL b2b_missing: %0d events left want 0", sb.size()); end
  endtask

  // Ready low: code 0 held stable, then 0 and 5 drain on consecutive cycles.
  task automatic test_ready_hold();
    bit   got = 0;
    bit   hold_ok = 1;
    int   last_pop = -1;
    exp_t e;
    do_reset();
    key_ready = 1'b0;
    keys = 16'h0021;
    sb.push_back('{code: 4'd0, rel: 1'b0});
    sb.push_back('{code: 4'd5, rel: 1'b0});
    en = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge aclk);
      if (key_valid) got = 1;
    end
    total++; if (!got) begin bad++; $display("FAIL hold_timeout: key_valid 0 want 1"); end
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (key_valid !== 1'b1 || key_code !== 4'd0) hold_ok = 0;
    end
    total++; if (!hold_ok) begin bad++; $display("FAIL hold_stable: got %b/%h want 1/0", key_valid, key_code); end
    key_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (key_valid && key_ready && sb.size() != 0) begin
        e = sb.pop_front();
        total++;
        if (key_code !== e.code) begin bad++; $display("FAIL hold_event: got %h want %h", key_code, e.code); end
        if (last_pop >= 0) begin
          total++;
          if (i != last_pop + 1) begin bad++; $display("FAIL hold_spacing: got %0d want %0d", i, last_pop + 1); end
        end
        last_pop = i;
      end
      @(negedge aclk);
    end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL hold_missing: %0d left want 0", sb.size()); end
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL hold_drained: key_valid %b want 0", key_valid); end
  endtask

  // Key 0 toggled every scan never debounces; once held it does.
  task automatic test_toggle();
    bit saw = 0;
    do_reset();
    key_ready = 1'b0;
    keys = 16'h0001;
    en = 1'b1;
    for (int s = 0; s < 8; s++) begin
      wait_eval();
      if (key_valid) saw = 1;
      keys[0] = ~keys[0];
    end
    total++; if (saw || key_valid !== 1'b0) begin bad++; $display("FAIL toggle_event: key_valid 1 want 0"); end
    repeat (3) wait_eval();
    total++;
    if (key_valid !== 1'b1 || key_code !== 4'd0) begin
      bad++; $display("FAIL toggle_settle: got %b/%h want 1/0", key_valid, key_code);
    end
  endtask

  // Repeated press of key 0 while its event is pending sets ovf; ovf_clr clears it.
  task automatic test_ovf();
    do_reset();
    key_ready = 1'b0;
    keys = 16'h0001;
    en = 1'b1;
    repeat (3) wait_eval(); keys[0] = 1'b0;
    repeat (3) wait_eval(); keys[0] = 1'b1;
    repeat (3) wait_eval();
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_early: got %b want 0", ovf); end
    total++;
    if (key_valid !== 1'b1 || key_code !== 4'd0) begin
      bad++; $display("FAIL ovf_keyreg: got %b/%h want 1/0", key_valid, key_code);
    end
    keys[0] = 1'b0;
    repeat (3) wait_eval(); keys[0] = 1'b1;
    repeat (3) wait_eval();
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", ovf); end
    ovf_clr = 1'b1;
    @(negedge aclk);
    ovf_clr = 1'b0;
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clr: got %b want 0", ovf); end
  endtask

  // Dropping en during row 2 idles the rows; re-enabling restarts at row 0.
  task automatic test_en_drop();
    bit got = 0;
    bit idle_ok = 1;
    int dwell = 0;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge aclk);
      if (row_n === 4'b1011) got = 1;
    end
    total++; if (!got) begin bad++; $display("FAIL en_row2_timeout: row_n %h want b", row_n); end
    en = 1'b0;
    @(negedge aclk);
    total++; if (row_n !== 4'hF) begin bad++; $display("FAIL en_drop: row_n %h want f", row_n); end
    repeat (5) begin
      @(negedge aclk);
      if (row_n !== 4'hF) idle_ok = 0;
    end
    total++; if (!idle_ok) begin bad++; $display("FAIL en_idle: row_n %h want f", row_n); end
    en = 1'b1;
    @(negedge aclk);
    total++; if (row_n !== 4'b1110) begin bad++; $display("FAIL en_restart: row_n %h want e", row_n); end
    while (row_n === 4'b1110 && dwell < 50) begin
      dwell++;
      @(negedge aclk);
    end
    total++; if (dwell != 8) begin bad++; $display("FAIL en_dwell: got %0d want 8", dwell); end
  endtask

  // Reset mid-scan idles the rows and discards pending events.
  task automatic test_reset_mid();
    bit got = 0;
    bit saw = 0;
    do_reset();
    key_ready = 1'b0;
    keys = 16'h0021;
    en = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge aclk);
      if (key_valid) got = 1;
    end
    repeat (10) @(negedge aclk);
    reset = 1'b1;
    @(negedge aclk);
    total++; if (row_n !== 4'hF) begin bad++; $display("FAIL mid_row_n: got %h want f", row_n); end
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", key_valid); end
    keys = '0;
    reset = 1'b0;
    repeat (120) begin
      @(negedge aclk);
      if (key_valid) saw = 1;
    end
    total++; if (saw) begin bad++; $display("FAIL mid_lost: key_valid 1 want 0 (code %h)", key_code); end
  endtask

`ifdef KEYPAD_RELEASE_EVENT_EN
  // Press then release key 5: press event followed by release event.
  task automatic test_release();
    bit   popped;
    exp_t e;
    do_reset();
    en = 1'b1;
    wait_eval();
    for (int ph = 0; ph < 2; ph++) begin
      keys[5] = (ph == 0);
      sb.push_back('{code: 4'd5, rel: (ph == 1)});
      popped = 0;
      for (int i = 0; i < 110 && !popped; i++) begin
        @(negedge aclk);
        if (key_valid && key_ready) begin
          e = sb.pop_front();
          popped = 1;
          total++;
          if (key_code !== e.code || key_release !== e.rel) begin
            bad++; $display("FAIL rel_event: got %h/%b want %h/%b", key_code, key_release, e.code, e.rel);
          end
        end
      end
      if (!popped) begin
        total++; bad++; $display("FAIL rel_timeout: phase %0d no event", ph);
      end
    end
  endtask
`endif

  initial begin
    keys = '0;
    test_reset();
    test_back_to_back();
    test_ready_hold();
    test_toggle();
    test_ovf();
    test_en_drop();
    test_reset_mid();
`ifdef KEYPAD_RELEASE_EVENT_EN
    test_release();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
